multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised successor of the arithmetic-processor control unit: one explicit-state multicycle FSM
//  (IDLE/FETCH/DECODE/EXEC/SHIFT/MEM/WB) driving the existing datapath selects and enables.
//  Adds conditional branches on Z_FLAG/N_FLAG, a MEM_REQ/MEM_RDY wait-state handshake,
//  a parametrised shift count and an illegal-opcode flag. Sits between the instruction register and the datapath.
// PARAMETERS
//  INST_W   16  instruction width; opcode = INSTR[INST_W-1 -: 4]
//  SHAMT_W  6   shift-amount field width, INSTR[SHAMT_W-1:0]; also the shift-counter width
//  OAP_W    3   ALU op width; R-type OAP = INSTR[OAP_W-1:0]
// PORTS
//  CLK              in   1        clock, rising edge
//  RST_N            in   1        asynchronous, active-low reset
//  INSTR            in   INST_W   instruction-register output
//  Z_FLAG, N_FLAG   in   1        ALU zero/negative flags, valid in EXEC
//  MEM_RDY          in   1        data memory done with the current access
//  INST_REG_EN, PC_EN  out 1      IR load; PC load
//  PC_MUX_SEL       out  2        00 = PC+1, 01 = PC+sext(INSTR[7:0])
//  RF_EN, LDA, LDQ  out  1        register-file write; A/Q register loads
//  A_SEL, B_SEL, D_SEL  out 2     datapath operand and writeback selects
//  OAP              out  OAP_W    ALU operation
//  SL, SR, SR_SEL   out  1        shift left; shift right; arithmetic right
//  PLUS1_SEL, INST_TYPE_MUX_SEL, WB_SEL, UL_SEL  out 1   address+1, S-type field mux, store-data mux, upper/lower half
//  MEM_REQ, WR_EN   out  1        memory access request; write qualifier
//  ILLEGAL          out  1        one-cycle pulse in DECODE for opcodes E/F
//  BUSY             out  1        high in every state except IDLE
//  STATE            out  3        current state encoding (debug)
// BEHAVIOUR
//  - Reset (async, RST_N=0): state=IDLE and opcode/shamt/half registers cleared.
//    All outputs 0 while reset is asserted and in IDLE. The first cycle after release is IDLE, then FETCH.
//    Assertion mid-instruction aborts it immediately; no partial RF/memory write follows.
//  - Outputs are a Moore decode of the registered state plus the opcode latched in DECODE.
//    A later INSTR change does not affect the instruction in flight.
//  - FETCH: INST_REG_EN=1, PC_EN=1, PC_MUX_SEL=00 -> DECODE.
//  - DECODE: latch opcode, shamt and OAP. Opcode E/F: ILLEGAL=1 -> FETCH. Otherwise -> EXEC.
//  - EXEC:
//    - ALU ops: 0 R-type (B_SEL=10, OAP=INSTR), 1 ADDI (B_SEL=11, OAP=000), 2 ANDI (B_SEL=11, OAP=100). LDA=1 -> WB.
//    - Shifts: 4 SLL, 5 SRL, 6 SRA (SR_SEL=1). LDA=1 -> SHIFT, or -> WB when shamt==0.
//    - Loads 7-9, stores A-C: LDA=1, and LDQ=1 for stores -> MEM.
//    - Branches: 3 BEQZ, D BLTZ. If Z (resp. N) is set, PC_EN=1 and PC_MUX_SEL=01; either way -> FETCH.
//  - SHIFT: counter loads shamt on entry and decrements each cycle. SL or SR is high for exactly shamt cycles;
//    the cycle the counter reaches 1 -> WB. shamt = 2^SHAMT_W-1 must work (no wrap).
//  - MEM: MEM_REQ=1, and WR_EN=1 for stores. Outputs are held stable while MEM_RDY=0; no timeout.
//    - On MEM_RDY=1 the half completes. Two-half ops (LW=7, SW=A) then toggle UL_SEL 0->1, set PLUS1_SEL=1
//      and stay in MEM.
//    - Single-half ops: 8/B upper (UL_SEL=1), 9/C lower (UL_SEL=0).
//    - After the last half, loads -> WB and stores -> FETCH.
//    - MEM_RDY already high on MEM entry: the access completes in 1 cycle.
//  - WB: RF_EN=1, D_SEL=01 (ALU/shift) or 10 (load) -> FETCH. RF_EN is high for exactly one cycle per instruction.
//  - Latency in cycles, FETCH to next FETCH exclusive:
//    ALU 4; shift 4+shamt; branch 3; load/store 3 + sum of access cycles (+1 for WB on loads).
//  - MEM_RDY outside MEM is ignored. Z/N outside EXEC are ignored.
// STRUCTURE
//  - ctrl_pkg: opcode localparams (OP_RTYPE..OP_BLTZ), state encodings ST_IDLE..ST_WB, select-code constants.
//  - One sub-module, ctrl_shift_counter: load/decrement/last-cycle flag, SHAMT_W wide.
//  - State register, latched fields and the output decode stay in this module.
// TESTING
//  - Reset held 3 cycles then released: all outputs 0 and STATE=IDLE; FETCH in the 2nd cycle after release.
//  - ADDI 0x1xxx: exactly 4-cycle sequence with LDA in EXEC and RF_EN only in WB; R-type OAP=INSTR[2:0].
//  - SRA with shamt=5: SR=SR_SEL=1 for 5 consecutive cycles. shamt=0: no SR, WB in cycle 4. shamt=63: 63 SR cycles.
//  - SW with MEM_RDY low 3 cycles per half: MEM_REQ/WR_EN held; UL_SEL 0 then 1; no RF_EN; back to FETCH.
//  - BEQZ: Z=1 -> PC_MUX_SEL=01 with PC_EN in EXEC; Z=0 -> no PC_EN in EXEC. Opcode 0xF -> ILLEGAL pulse,
//    next state FETCH.
//  - RST_N dropped during SHIFT and during a MEM wait: outputs 0 asynchronously, no RF_EN/WR_EN afterward,
//    clean restart at FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, datapath select codes
// and small opcode-class helpers.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_BEQZ  = 4'h3;
  localparam logic [3:0] OP_SLL   = 4'h4;
  localparam logic [3:0] OP_SRL   = 4'h5;
  localparam logic [3:0] OP_SRA   = 4'h6;
  localparam logic [3:0] OP_LW    = 4'h7;
  localparam logic [3:0] OP_LWU   = 4'h8;
  localparam logic [3:0] OP_LWL   = 4'h9;
  localparam logic [3:0] OP_SW    = 4'hA;
  localparam logic [3:0] OP_SWU   = 4'hB;
  localparam logic [3:0] OP_SWL   = 4'hC;
  localparam logic [3:0] OP_BLTZ  = 4'hD;
  localparam logic [3:0] OP_ILL_E = 4'hE;
  localparam logic [3:0] OP_ILL_F = 4'hF;

  localparam logic [1:0] PC_SEL_INC    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] A_SEL_RF      = 2'b01;
  localparam logic [1:0] B_SEL_REG     = 2'b10;
  localparam logic [1:0] B_SEL_IMM     = 2'b11;
  localparam logic [1:0] D_SEL_ALU     = 2'b01;
  localparam logic [1:0] D_SEL_MEM     = 2'b10;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LWU) || (op == OP_LWL);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SWU) || (op == OP_SWL);
  endfunction

  function automatic logic is_two_half(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_upper(input logic [3:0] op);
    return (op == OP_LWU) || (op == OP_SWU);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Bundle between the instruction register / datapath / data memory and the control FSM.
interface multicycle_ctrl_fsm_if #(
  parameter int INST_W = 16,
  parameter int OAP_W  = 3
);
  logic [INST_W-1:0] INSTR;
  logic              Z_FLAG;
  logic              N_FLAG;
  // Memory handshake: MEM_REQ (with WR_EN/UL_SEL/PLUS1_SEL) stays stable while MEM_RDY=0;
  // a half completes in any MEM cycle where MEM_REQ and MEM_RDY are both high.
  logic              MEM_RDY;
  logic              MEM_REQ;
  logic              WR_EN;
  logic              INST_REG_EN;
  logic              PC_EN;
  logic [1:0]        PC_MUX_SEL;
  logic              RF_EN;
  logic              LDA;
  logic              LDQ;
  logic [1:0]        A_SEL;
  logic [1:0]        B_SEL;
  logic [1:0]        D_SEL;
  logic [OAP_W-1:0]  OAP;
  logic              SL;
  logic              SR;
  logic              SR_SEL;
  logic              PLUS1_SEL;
  logic              INST_TYPE_MUX_SEL;
  logic              WB_SEL;
  logic              UL_SEL;
  logic              ILLEGAL;
  logic              BUSY;
  logic [2:0]        STATE;

  modport master (
    input  INSTR, Z_FLAG, N_FLAG, MEM_RDY,
    output MEM_REQ, WR_EN, INST_REG_EN, PC_EN, PC_MUX_SEL, RF_EN, LDA, LDQ,
           A_SEL, B_SEL, D_SEL, OAP, SL, SR, SR_SEL, PLUS1_SEL, INST_TYPE_MUX_SEL,
           WB_SEL, UL_SEL, ILLEGAL, BUSY, STATE
  );

  modport slave (
    output INSTR, Z_FLAG, N_FLAG, MEM_RDY,
    input  MEM_REQ, WR_EN, INST_REG_EN, PC_EN, PC_MUX_SEL, RF_EN, LDA, LDQ,
           A_SEL, B_SEL, D_SEL, OAP, SL, SR, SR_SEL, PLUS1_SEL, INST_TYPE_MUX_SEL,
           WB_SEL, UL_SEL, ILLEGAL, BUSY, STATE
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_shift_counter.sv
// Shift-cycle counter: loads the shift amount before SHIFT, counts down while shifting and
// flags the final shift cycle.
module multicycle_ctrl_fsm_shift_counter #(
  parameter int SHAMT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               last_o
);

  logic [SHAMT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= shamt_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  // Counting down to 1 rather than 0 lets the all-ones shift amount run without wrap.
  assign last_o = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM: Moore decode of the registered state plus the opcode latched in DECODE,
// driving datapath selects/enables, branch resolution and the data-memory wait-state handshake.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int INST_W  = 16,
  parameter int SHAMT_W = 6,
  parameter int OAP_W   = 3
) (
  input logic                  CLK,
  input logic                  RST_N,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [OAP_W-1:0] OAP_ADD = '0;
  localparam logic [OAP_W-1:0] OAP_AND = OAP_W'(4);

  state_e             state_q, state_d;
  logic [3:0]         opcode_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [OAP_W-1:0]   oap_q;
  logic               half_q, half_d;
  logic [3:0]         instr_op;
  logic               shift_last;
  logic               unused_instr;

  assign instr_op     = bus.INSTR[INST_W-1 -: 4];
  assign unused_instr = ^bus.INSTR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      shamt_q  <= '0;
      oap_q    <= '0;
      half_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= instr_op;
        shamt_q  <= bus.INSTR[SHAMT_W-1:0];
        oap_q    <= bus.INSTR[OAP_W-1:0];
      end
    end
  end

  multicycle_ctrl_fsm_shift_counter #(.SHAMT_W(SHAMT_W)) u_shift_cnt (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .load_i  ((state_q == ST_EXEC) && is_shift(opcode_q)),
    .dec_i   (state_q == ST_SHIFT),
    .shamt_i (shamt_q),
    .last_o  (shift_last)
  );

  assign bus.BUSY  = (state_q != ST_IDLE);
  assign bus.STATE = state_q;

  always_comb begin
    state_d               = state_q;
    half_d                = half_q;
    bus.INST_REG_EN       = 1'b0;
    bus.PC_EN             = 1'b0;
    bus.PC_MUX_SEL        = PC_SEL_INC;
    bus.RF_EN             = 1'b0;
    bus.LDA               = 1'b0;
    bus.LDQ               = 1'b0;
    bus.A_SEL             = 2'b00;
    bus.B_SEL             = 2'b00;
    bus.D_SEL             = 2'b00;
    bus.OAP               = OAP_ADD;
    bus.SL                = 1'b0;
    bus.SR                = 1'b0;
    bus.SR_SEL            = 1'b0;
    bus.PLUS1_SEL         = 1'b0;
    bus.INST_TYPE_MUX_SEL = 1'b0;
    bus.WB_SEL            = 1'b0;
    bus.UL_SEL            = 1'b0;
    bus.MEM_REQ           = 1'b0;
    bus.WR_EN             = 1'b0;
    bus.ILLEGAL           = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        bus.INST_REG_EN = 1'b1;
        bus.PC_EN       = 1'b1;
        state_d         = ST_DECODE;
      end

      // The IR was loaded in FETCH, so the live INSTR is the instruction being decoded.
      ST_DECODE: begin
        if ((instr_op == OP_ILL_E) || (instr_op == OP_ILL_F)) begin
          bus.ILLEGAL = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        bus.A_SEL = A_SEL_RF;
        half_d    = 1'b0;
        case (opcode_q)
          OP_RTYPE: begin
            bus.B_SEL = B_SEL_REG;
            bus.OAP   = oap_q;
            bus.LDA   = 1'b1;
            state_d   = ST_WB;
          end
          OP_ADDI: begin
            bus.B_SEL = B_SEL_IMM;
            bus.LDA   = 1'b1;
            state_d   = ST_WB;
          end
          OP_ANDI: begin
            bus.B_SEL = B_SEL_IMM;
            bus.OAP   = OAP_AND;
            bus.LDA   = 1'b1;
            state_d   = ST_WB;
          end
          OP_BEQZ: begin
            if (bus.Z_FLAG) begin
              bus.PC_EN      = 1'b1;
              bus.PC_MUX_SEL = PC_SEL_BRANCH;
            end
            state_d = ST_FETCH;
          end
          OP_BLTZ: begin
            if (bus.N_FLAG) begin
              bus.PC_EN      = 1'b1;
              bus.PC_MUX_SEL = PC_SEL_BRANCH;
            end
            state_d = ST_FETCH;
          end
          default: begin
            if (is_shift(opcode_q)) begin
              bus.LDA    = 1'b1;
              bus.SR_SEL = (opcode_q == OP_SRA);
              state_d    = (shamt_q == '0) ? ST_WB : ST_SHIFT;
            end else if (is_load(opcode_q) || is_store(opcode_q)) begin
              bus.LDA               = 1'b1;
              bus.LDQ               = is_store(opcode_q);
              bus.B_SEL             = B_SEL_IMM;
              bus.INST_TYPE_MUX_SEL = is_store(opcode_q);
              state_d               = ST_MEM;
            end else begin
              state_d = ST_FETCH;
            end
          end
        endcase
      end

      ST_SHIFT: begin
        bus.SL     = (opcode_q == OP_SLL);
        bus.SR     = (opcode_q != OP_SLL);
        bus.SR_SEL = (opcode_q == OP_SRA);
        if (shift_last) state_d = ST_WB;
      end

      // Outputs depend only on state/opcode/half, so they hold steady across wait cycles.
      ST_MEM: begin
        bus.MEM_REQ   = 1'b1;
        bus.WR_EN     = is_store(opcode_q);
        bus.WB_SEL    = is_store(opcode_q);
        bus.UL_SEL    = is_two_half(opcode_q) ? half_q : is_upper(opcode_q);
        bus.PLUS1_SEL = is_two_half(opcode_q) && half_q;
        if (bus.MEM_RDY) begin
          if (is_two_half(opcode_q) && !half_q) begin
            half_d = 1'b1;
          end else begin
            half_d  = 1'b0;
            state_d = is_load(opcode_q) ? ST_WB : ST_FETCH;
          end
        end
      end

      ST_WB: begin
        bus.RF_EN = 1'b1;
        bus.D_SEL = is_load(opcode_q) ? D_SEL_MEM : D_SEL_ALU;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed scenarios plus random instructions, each checked against
// per-instruction totals derived from the instruction-class rules (latency, enable counts, half order).
module tb_multicycle_ctrl_fsm;

  logic CLK;
  logic RST_N;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   synced  = 0;

  multicycle_ctrl_fsm_if #(.INST_W(16), .OAP_W(3)) bus ();

  multicycle_ctrl_fsm #(.INST_W(16), .SHAMT_W(6), .OAP_W(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] all_outs();
    return {2'b00, bus.INST_REG_EN, bus.PC_EN, bus.PC_MUX_SEL, bus.RF_EN, bus.LDA, bus.LDQ,
            bus.A_SEL, bus.B_SEL, bus.D_SEL, bus.OAP, bus.SL, bus.SR, bus.SR_SEL,
            bus.PLUS1_SEL, bus.INST_TYPE_MUX_SEL, bus.WB_SEL, bus.UL_SEL, bus.MEM_REQ,
            bus.WR_EN, bus.ILLEGAL, bus.BUSY, bus.STATE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drops reset at the current time (asynchronously), holds it, releases just after a rising edge.
  task automatic do_reset(input int hold);
    RST_N       = 1'b0;
    bus.MEM_RDY = 1'b0;
    #1;
    check("rst_async_zero", all_outs(), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK); #2;
      check("rst_hold_zero", all_outs(), 32'd0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK); #2;
    check("idle_after_rst", all_outs(), 32'd0);
    synced = 0;
  endtask

  // Runs the first n cycles of an instruction with memory never ready.
  task automatic step_partial(input logic [15:0] ins, input int n);
    for (int cyc = 0; cyc < n; cyc++) begin
      if (!(cyc == 0 && synced)) @(negedge CLK);
      bus.INSTR   = (cyc < 2) ? ins : 16'($urandom);
      bus.Z_FLAG  = 1'b0;
      bus.N_FLAG  = 1'b0;
      bus.MEM_RDY = 1'b0;
      #2;
    end
    synced = 0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input logic n,
                           input int w0, input int w1);
    logic [3:0]  op;
    int          sh, halves, acc, lat_exp;
    bit          is_alu, is_br, is_sh, is_ld, is_st, is_ill, taken, has_rf, has_lda;
    logic [31:0] ul_exp, p1_exp, ul_bits, p1_bits;
    int          cyc, wait_left;
    int          c_lda, c_ldq, c_rf, c_sl, c_sr, c_srsel, c_req, c_wr, c_pc, c_br, c_ill;
    int          c_unst, c_idle, rf_cyc, lda_cyc;
    logic [2:0]  oap_seen;
    logic [1:0]  bsel_seen, dsel_seen;
    logic        prev_wait;
    logic [4:0]  prev_mem, cur_mem;
    bit          done;

    op      = ins[15:12];
    sh      = int'(ins[5:0]);
    is_alu  = (op <= 4'd2);
    is_br   = (op == 4'd3) || (op == 4'd13);
    is_sh   = (op >= 4'd4) && (op <= 4'd6);
    is_ld   = (op >= 4'd7) && (op <= 4'd9);
    is_st   = (op >= 4'd10) && (op <= 4'd12);
    is_ill  = (op >= 4'd14);
    halves  = ((op == 4'd7) || (op == 4'd10)) ? 2 : 1;
    acc     = (is_ld || is_st) ? ((w0 + 1) + ((halves == 2) ? (w1 + 1) : 0)) : 0;
    taken   = ((op == 4'd3) && z) || ((op == 4'd13) && n);
    has_rf  = is_alu || is_sh || is_ld;
    has_lda = !(is_br || is_ill);
    lat_exp = is_alu ? 4 : is_sh ? 4 + sh : is_br ? 3 : is_ld ? 4 + acc : is_st ? 3 + acc : 2;
    // Half-completion records start from a leading 1 so the number of halves is checked too.
    if ((op == 4'd7) || (op == 4'd10)) begin
      ul_exp = 32'b101; p1_exp = 32'b101;
    end else if ((op == 4'd8) || (op == 4'd11)) begin
      ul_exp = 32'b11;  p1_exp = 32'b10;
    end else if ((op == 4'd9) || (op == 4'd12)) begin
      ul_exp = 32'b10;  p1_exp = 32'b10;
    end else begin
      ul_exp = 32'b1;   p1_exp = 32'b1;
    end

    cyc = 0; wait_left = w0; done = 0;
    c_lda = 0; c_ldq = 0; c_rf = 0; c_sl = 0; c_sr = 0; c_srsel = 0; c_req = 0; c_wr = 0;
    c_pc = 0; c_br = 0; c_ill = 0; c_unst = 0; c_idle = 0; rf_cyc = -1; lda_cyc = -1;
    ul_bits = 32'b1; p1_bits = 32'b1; oap_seen = '0; bsel_seen = '0; dsel_seen = '0;
    prev_wait = 1'b0; prev_mem = '0;

    while (!done) begin
      if (!(cyc == 0 && synced)) @(negedge CLK);
      bus.INSTR  = (cyc < 2) ? ins : 16'($urandom);
      bus.Z_FLAG = (cyc == 2) ? z : 1'($urandom);
      bus.N_FLAG = (cyc == 2) ? n : 1'($urandom);
      #1;
      bus.MEM_RDY = bus.MEM_REQ ? (wait_left == 0) : 1'($urandom);
      #1;
      if (cyc > 0 && bus.INST_REG_EN) begin
        done = 1;
      end else begin
        if (cyc == 0) check($sformatf("fetch_first[%h]", ins), 32'(bus.INST_REG_EN), 32'd1);
        if (bus.LDA) begin
          c_lda++; lda_cyc = cyc; oap_seen = bus.OAP; bsel_seen = bus.B_SEL;
        end
        if (bus.RF_EN) begin
          c_rf++; rf_cyc = cyc; dsel_seen = bus.D_SEL;
        end
        if (bus.LDQ) c_ldq++;
        if (bus.SL) c_sl++;
        if (bus.SR) c_sr++;
        if (bus.SR && bus.SR_SEL) c_srsel++;
        if (bus.WR_EN) c_wr++;
        if (bus.PC_EN) c_pc++;
        if (bus.PC_EN && (bus.PC_MUX_SEL == 2'b01)) c_br++;
        if (bus.ILLEGAL) c_ill++;
        if (!bus.BUSY) c_idle++;
        cur_mem = {bus.MEM_REQ, bus.WR_EN, bus.UL_SEL, bus.PLUS1_SEL, bus.WB_SEL};
        if (prev_wait && (cur_mem !== prev_mem)) c_unst++;
        prev_wait = bus.MEM_REQ && !bus.MEM_RDY;
        prev_mem  = cur_mem;
        if (bus.MEM_REQ) begin
          c_req++;
          if (bus.MEM_RDY) begin
            ul_bits   = {ul_bits[30:0], bus.UL_SEL};
            p1_bits   = {p1_bits[30:0], bus.PLUS1_SEL};
            wait_left = w1;
          end else begin
            wait_left--;
          end
        end
        cyc++;
        if (cyc > 400) begin
          check($sformatf("timeout[%h]", ins), 32'(cyc), 32'(lat_exp));
          done = 1;
        end
      end
    end
    synced = 1;

    check($sformatf("latency[%h]", ins),   32'(cyc),     32'(lat_exp));
    check($sformatf("lda_cnt[%h]", ins),   32'(c_lda),   has_lda ? 32'd1 : 32'd0);
    check($sformatf("ldq_cnt[%h]", ins),   32'(c_ldq),   is_st ? 32'd1 : 32'd0);
    check($sformatf("rf_cnt[%h]", ins),    32'(c_rf),    has_rf ? 32'd1 : 32'd0);
    check($sformatf("sl_cnt[%h]", ins),    32'(c_sl),    (op == 4'd4) ? 32'(sh) : 32'd0);
    check($sformatf("sr_cnt[%h]", ins),    32'(c_sr),    ((op == 4'd5) || (op == 4'd6)) ? 32'(sh) : 32'd0);
    check($sformatf("srsel_cnt[%h]", ins), 32'(c_srsel), (op == 4'd6) ? 32'(sh) : 32'd0);
    check($sformatf("memreq_cnt[%h]", ins), 32'(c_req),  32'(acc));
    check($sformatf("wren_cnt[%h]", ins),  32'(c_wr),    is_st ? 32'(acc) : 32'd0);
    check($sformatf("pcen_cnt[%h]", ins),  32'(c_pc),    taken ? 32'd2 : 32'd1);
    check($sformatf("branch_cnt[%h]", ins), 32'(c_br),   taken ? 32'd1 : 32'd0);
    check($sformatf("illegal_cnt[%h]", ins), 32'(c_ill), is_ill ? 32'd1 : 32'd0);
    check($sformatf("ul_order[%h]", ins),  ul_bits,      ul_exp);
    check($sformatf("plus1_order[%h]", ins), p1_bits,    p1_exp);
    check($sformatf("mem_hold[%h]", ins),  32'(c_unst),  32'd0);
    check($sformatf("busy_low[%h]", ins),  32'(c_idle),  32'd0);
    if (has_lda) check($sformatf("lda_cyc[%h]", ins), 32'(lda_cyc), 32'd2);
    if (has_rf) begin
      check($sformatf("rf_cyc[%h]", ins), 32'(rf_cyc), 32'(lat_exp - 1));
      check($sformatf("d_sel[%h]", ins),  32'(dsel_seen), is_ld ? 32'd2 : 32'd1);
    end
    if (is_alu) begin
      check($sformatf("oap[%h]", ins), 32'(oap_seen),
            (op == 4'd0) ? 32'(ins[2:0]) : (op == 4'd1) ? 32'd0 : 32'd4);
      check($sformatf("b_sel[%h]", ins), 32'(bsel_seen), (op == 4'd0) ? 32'd2 : 32'd3);
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    bus.INSTR   = '0;
    bus.Z_FLAG  = 1'b0;
    bus.N_FLAG  = 1'b0;
    bus.MEM_RDY = 1'b0;
    #3;
    do_reset(3);

    run_instr(16'h1234, 1'b0, 1'b0, 0, 0);
    run_instr(16'h0ABD, 1'b0, 1'b0, 0, 0);
    run_instr(16'h2F0F, 1'b1, 1'b1, 0, 0);
    run_instr(16'h6005, 1'b0, 1'b0, 0, 0);
    run_instr(16'h6000, 1'b0, 1'b0, 0, 0);
    run_instr(16'h603F, 1'b0, 1'b0, 0, 0);
    run_instr(16'h4003, 1'b0, 1'b0, 0, 0);
    run_instr(16'h5001, 1'b0, 1'b0, 0, 0);
    run_instr(16'hA000, 1'b0, 1'b0, 3, 3);
    run_instr(16'h7010, 1'b0, 1'b0, 2, 0);
    run_instr(16'h8000, 1'b0, 1'b0, 0, 0);
    run_instr(16'h9000, 1'b0, 1'b0, 1, 0);
    run_instr(16'hB000, 1'b0, 1'b0, 0, 0);
    run_instr(16'hC000, 1'b0, 1'b0, 2, 0);
    run_instr(16'h3000, 1'b1, 1'b0, 0, 0);
    run_instr(16'h3000, 1'b0, 1'b1, 0, 0);
    run_instr(16'hD000, 1'b0, 1'b1, 0, 0);
    run_instr(16'hD000, 1'b1, 1'b0, 0, 0);
    run_instr(16'hF000, 1'b0, 1'b0, 0, 0);
    run_instr(16'hE123, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom_range(0, 15))};
      run_instr(ins, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    step_partial(16'h4010, 6);
    check("abort_in_shift", 32'(bus.SL), 32'd1);
    do_reset(2);
    run_instr(16'h1000, 1'b0, 1'b0, 0, 0);

    step_partial(16'hA000, 6);
    check("abort_in_mem_wait", 32'({bus.MEM_REQ, bus.WR_EN}), 32'd3);
    do_reset(2);
    run_instr(16'h7000, 1'b0, 1'b0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
